xy_input_buffer: RTL and testbench

XY_INPUT_BUFFER -- requirements
Module: xy_input_buffer

---
 rtl/xy_input_buffer_if.sv | 24 ++
 rtl/xy_input_buffer.sv | 81 ++++++++
 tb/tb_xy_input_buffer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/xy_input_buffer_if.sv
// Handshake bundle between an upstream packet source, the XY input buffer and the switch input.
// The buffer itself uses the slave modport; whoever feeds and drains it uses master.
interface xy_input_buffer_if #(
    parameter int PACKET_W = 16,
    parameter int CNT_W    = 3
);
    logic                pckt_vld_i;
    logic [PACKET_W-1:0] pckt_i;
    logic                pckt_rdy_o;
    logic                pckt_vld_o;
    logic [PACKET_W-1:0] pckt_o;
    logic                pckt_rd_i;
    logic [CNT_W-1:0]    count_o;

    modport slave (
        input  pckt_vld_i, pckt_i, pckt_rd_i,
        output pckt_rdy_o, pckt_vld_o, pckt_o, count_o
    );

    modport master (
        output pckt_vld_i, pckt_i, pckt_rd_i,
        input  pckt_rdy_o, pckt_vld_o, pckt_o, count_o
    );
endinterface

// File: rtl/xy_input_buffer.sv
// First-word fall-through packet FIFO in front of one XY switch input port.
// Optional saturating drop counter enabled by defining XY_INPUT_BUFFER_DROP_CNT_EN.
module xy_input_buffer #(
    parameter int PACKET_W = 16,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 3
) (
    input  logic              clk_i,
    input  logic              rst_i,
`ifdef XY_INPUT_BUFFER_DROP_CNT_EN
    output logic [7:0]        drop_cnt_o,
`endif
    xy_input_buffer_if.slave  bus
);
    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [PACKET_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]    wrPtr_q, wrPtr_d;
    logic [PTR_W-1:0]    rdPtr_q, rdPtr_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                full, empty, wrEn, rdEn;

    // Ready depends only on stored occupancy, so a pop never frees a slot in the same cycle.
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);
    assign wrEn  = bus.pckt_vld_i & ~full  & ~rst_i;
    assign rdEn  = bus.pckt_rd_i  & ~empty & ~rst_i;

    always_comb begin
        wrPtr_d = wrPtr_q;
        rdPtr_d = rdPtr_q;
        count_d = count_q;
        if (wrEn) wrPtr_d = wrPtr_q + PTR_W'(1);
        if (rdEn) rdPtr_d = rdPtr_q + PTR_W'(1);
        case ({wrEn, rdEn})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
        if (rst_i) begin
            wrPtr_d = '0;
            rdPtr_d = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        wrPtr_q <= wrPtr_d;
        rdPtr_q <= rdPtr_d;
        count_q <= count_d;
    end

    // Storage is deliberately left out of reset; the pointers alone define what is valid.
    always_ff @(posedge clk_i) begin
        if (wrEn) mem_q[wrPtr_q] <= bus.pckt_i;
    end

    assign bus.pckt_rdy_o = ~full;
    assign bus.pckt_vld_o = ~empty;
    assign bus.pckt_o     = mem_q[rdPtr_q];
    assign bus.count_o    = count_q;

`ifdef XY_INPUT_BUFFER_DROP_CNT_EN
    logic [7:0] dropCnt_q, dropCnt_d;

    always_comb begin
        dropCnt_d = dropCnt_q;
        if (bus.pckt_vld_i && full && (dropCnt_q != 8'hFF)) dropCnt_d = dropCnt_q + 8'd1;
        if (rst_i) dropCnt_d = '0;
    end

    always_ff @(posedge clk_i) begin
        dropCnt_q <= dropCnt_d;
    end

    assign drop_cnt_o = dropCnt_q;
`else
    // Without the counter, offers made while full are simply never accepted.
`endif
endmodule

// File: tb/tb_xy_input_buffer.sv
// Self-checking bench for xy_input_buffer: queue-based reference model compared every cycle,
// plus directed scenarios with literal expectations. Drop-counter checks under XY_INPUT_BUFFER_DROP_CNT_EN.
module tb_xy_input_buffer;
    localparam int PACKET_W = 16;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 3;

    logic clk;
    logic rst;

    xy_input_buffer_if #(.PACKET_W(PACKET_W), .CNT_W(CNT_W)) bus ();

`ifdef XY_INPUT_BUFFER_DROP_CNT_EN
    logic [7:0] dropCnt;
    int         modelDrop;
`endif

    xy_input_buffer #(
        .PACKET_W(PACKET_W),
        .DEPTH   (DEPTH),
        .CNT_W   (CNT_W)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst),
`ifdef XY_INPUT_BUFFER_DROP_CNT_EN
        .drop_cnt_o(dropCnt),
`endif
        .bus       (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [PACKET_W-1:0] model [$];
    int checks = 0;
    int errors = 0;

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a plain queue holding at most DEPTH packets, updated once per clock edge.
    task automatic modelStep(input logic vld, input logic [PACKET_W-1:0] pkt, input logic rd, input logic rs);
        bit wasFull;
        if (rs) begin
            model.delete();
`ifdef XY_INPUT_BUFFER_DROP_CNT_EN
            modelDrop = 0;
`endif
            return;
        end
        wasFull = (model.size() == DEPTH);
`ifdef XY_INPUT_BUFFER_DROP_CNT_EN
        if (vld && wasFull && modelDrop < 255) modelDrop++;
`endif
        if (rd && model.size() != 0) void'(model.pop_front());
        if (vld && !wasFull) model.push_back(pkt);
    endtask

    task automatic checkOutput();
        checkValue("count_o", 32'(bus.count_o), 32'(model.size()));
        checkValue("pckt_vld_o", 32'(bus.pckt_vld_o), 32'(model.size() != 0));
        checkValue("pckt_rdy_o", 32'(bus.pckt_rdy_o), 32'(model.size() != DEPTH));
        if (model.size() != 0) checkValue("pckt_o", 32'(bus.pckt_o), 32'(model[0]));
`ifdef XY_INPUT_BUFFER_DROP_CNT_EN
        checkValue("drop_cnt_o", 32'(dropCnt), 32'(modelDrop));
`endif
    endtask

    // Drive at the falling edge, advance the model on the rising edge, check at the next falling edge.
    task automatic applyStimulus(input logic vld, input logic [PACKET_W-1:0] pkt, input logic rd, input logic rs);
        bus.pckt_vld_i = vld;
        bus.pckt_i     = pkt;
        bus.pckt_rd_i  = rd;
        rst            = rs;
        @(posedge clk);
        modelStep(vld, pkt, rd, rs);
        @(negedge clk);
        checkOutput();
    endtask

    initial begin
        bus.pckt_vld_i = 1'b0;
        bus.pckt_i     = '0;
        bus.pckt_rd_i  = 1'b0;
        rst            = 1'b1;
`ifdef XY_INPUT_BUFFER_DROP_CNT_EN
        modelDrop = 0;
`endif
        @(negedge clk);

        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        checkValue("reset count", 32'(bus.count_o), 32'd0);
        checkValue("reset vld", 32'(bus.pckt_vld_o), 32'd0);
        checkValue("reset rdy", 32'(bus.pckt_rdy_o), 32'd1);

        // Single write: must not appear combinationally, then appears one cycle later.
        rst = 1'b0;
        bus.pckt_vld_i = 1'b1;
        bus.pckt_i     = 16'h1234;
        #1;
        checkValue("no comb fallthrough", 32'(bus.pckt_vld_o), 32'd0);
        applyStimulus(1'b1, 16'h1234, 1'b0, 1'b0);
        checkValue("first pckt_o", 32'(bus.pckt_o), 32'h1234);
        checkValue("first vld", 32'(bus.pckt_vld_o), 32'd1);
        checkValue("first count", 32'(bus.count_o), 32'd1);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        applyStimulus(1'b0, '0, 1'b1, 1'b0);
        checkValue("read when empty ignored", 32'(bus.count_o), 32'd0);

        // Fill, attempt overflow, drain in order.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'hA001 + 16'(i), 1'b0, 1'b0);
        checkValue("full rdy", 32'(bus.pckt_rdy_o), 32'd0);
        checkValue("full count", 32'(bus.count_o), 32'd4);
        applyStimulus(1'b1, 16'hA005, 1'b0, 1'b0);
        checkValue("overflow count", 32'(bus.count_o), 32'd4);
        for (int i = 0; i < 4; i++) begin
            checkValue("drain order", 32'(bus.pckt_o), 32'hA001 + i);
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkValue("drained vld", 32'(bus.pckt_vld_o), 32'd0);

        // Full with simultaneous write and pop: the write must be dropped.
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'hB001 + 16'(i), 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hBEEF, 1'b1, 1'b0);
        checkValue("full wr+rd count", 32'(bus.count_o), 32'd3);
        for (int i = 0; i < 3; i++) begin
            checkValue("after full wr+rd", 32'(bus.pckt_o), 32'hB002 + i);
            applyStimulus(1'b0, '0, 1'b1, 1'b0);
        end
        checkValue("BEEF dropped", 32'(bus.pckt_vld_o), 32'd0);

        // Steady state at count 2 with pointer wrap.
        applyStimulus(1'b1, 16'hC000, 1'b0, 1'b0);
        applyStimulus(1'b1, 16'hC001, 1'b0, 1'b0);
        for (int i = 0; i < 10; i++) begin
            checkValue("steady head", 32'(bus.pckt_o), 32'hC000 + i);
            applyStimulus(1'b1, 16'hC002 + 16'(i), 1'b1, 1'b0);
            checkValue("steady count", 32'(bus.count_o), 32'd2);
        end
        checkValue("steady final head", 32'(bus.pckt_o), 32'hC00A);

        // Reset mid-operation with traffic presented in the reset cycle.
        applyStimulus(1'b1, 16'hD000, 1'b0, 1'b0);
        checkValue("pre-reset count", 32'(bus.count_o), 32'd3);
        applyStimulus(1'b1, 16'hD001, 1'b1, 1'b1);
        checkValue("mid reset count", 32'(bus.count_o), 32'd0);
        checkValue("mid reset vld", 32'(bus.pckt_vld_o), 32'd0);
        checkValue("mid reset rdy", 32'(bus.pckt_rdy_o), 32'd1);

        // Randomised traffic in phases biased toward filling, draining and balance.
        for (int phase = 0; phase < 4; phase++) begin
            for (int n = 0; n < 500; n++) begin
                logic vld, rd, rs;
                case (phase)
                    0:       begin vld = ($urandom_range(0, 3) != 0); rd = ($urandom_range(0, 3) == 0); end
                    1:       begin vld = ($urandom_range(0, 3) == 0); rd = ($urandom_range(0, 3) != 0); end
                    default: begin vld = $urandom_range(0, 1) != 0;  rd = $urandom_range(0, 1) != 0; end
                endcase
                rs = ($urandom_range(0, 63) == 0);
                applyStimulus(vld, PACKET_W'($urandom), rd, rs);
            end
        end

`ifdef XY_INPUT_BUFFER_DROP_CNT_EN
        applyStimulus(1'b0, '0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, 16'hE000 + 16'(i), 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) applyStimulus(1'b1, 16'hEEEE, 1'b0, 1'b0);
        checkValue("drop saturate", 32'(dropCnt), 32'd255);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
